// File: rtl/uart_reg_if.sv
// Bundle between the register bridge and its uart FIFOs / register block.
// The master side is the bridge; the slave side is the surrounding environment.
interface uart_reg_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;

    modport master (
        input  rx_empty, rx_data, tx_full, reg_rdata,
        output rd_uart, wr_uart, tx_data,
        output reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output rx_empty, rx_data, tx_full, reg_rdata,
        input  rd_uart, wr_uart, tx_data,
        input  reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Byte-protocol responder: 'W' addr data / 'R' addr frames from the uart rx FIFO
// become register-bus strobes, answered with one byte into the uart tx FIFO.
module uart_reg_bridge #(
    parameter int TIMEOUT = 500000,
    parameter int TO_BIT  = 19
) (
    input  logic        clk,
    input  logic        reset,
    uart_reg_if.master  bus,
    output logic        busy,
    output logic        err_tick
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
    } state_t;

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic              op_wr, op_wr_nx;
    logic [7:0]        addr_nx, wdata_nx, tx_nx;
    logic [TO_BIT-1:0] cnt, cnt_nx;
    logic              pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_wr         <= 1'b0;
            cnt           <= '0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.tx_data   <= '0;
        end else begin
            state         <= state_nx;
            op_wr         <= op_wr_nx;
            cnt           <= cnt_nx;
            bus.reg_addr  <= addr_nx;
            bus.reg_wdata <= wdata_nx;
            bus.tx_data   <= tx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        op_wr_nx    = op_wr;
        addr_nx     = bus.reg_addr;
        wdata_nx    = bus.reg_wdata;
        tx_nx       = bus.tx_data;
        cnt_nx      = '0;
        pop         = 1'b0;
        err_tick    = 1'b0;
        bus.wr_uart = 1'b0;
        bus.reg_wr  = 1'b0;
        bus.reg_rd  = 1'b0;
        unique case (state)
            IDLE: begin
                pop = ~bus.rx_empty;
                if (pop) begin
                    if (bus.rx_data == CH_W) begin
                        op_wr_nx = 1'b1;
                        state_nx = GET_ADDR;
                    end else if (bus.rx_data == CH_R) begin
                        op_wr_nx = 1'b0;
                        state_nx = GET_ADDR;
                    end else begin
                        tx_nx    = CH_E;
                        state_nx = SEND;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // An arriving byte always beats an expiring counter.
                if (!bus.rx_empty) begin
                    pop = 1'b1;
                    if (state == GET_ADDR) begin
                        addr_nx  = bus.rx_data;
                        state_nx = op_wr ? GET_DATA : BUS_RD;
                    end else begin
                        wdata_nx = bus.rx_data;
                        state_nx = BUS_WR;
                    end
                end else if (cnt == TO_LAST) begin
                    err_tick = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            BUS_WR: begin
                bus.reg_wr = 1'b1;
                tx_nx      = CH_K;
                state_nx   = SEND;
            end
            BUS_RD: begin
                bus.reg_rd = 1'b1;
                state_nx   = RD_WAIT;
            end
            RD_WAIT: begin
                tx_nx    = bus.reg_rdata;
                state_nx = SEND;
            end
            SEND: begin
                bus.wr_uart = ~bus.tx_full;
                if (!bus.tx_full) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rd_uart = pop & ~reset;
    assign busy        = (state != IDLE);
endmodule
